// File: rtl/eth_pkg.sv
// Shared types for the Ethernet byte packer.
//   ETH_OUT_BYTES : default output word width in bytes
//   eth_word_t    : layout of one packed output word at the default width,
//                   {data, keep, last, err}; the FIFO stores this same bit
//                   order as a flat vector so other widths use it too.
//   pack_state_t  : overflow handling state (PASS, DROP, TERM)
package eth_pkg;

  localparam int ETH_OUT_BYTES = 4;

  typedef struct packed {
    logic [8*ETH_OUT_BYTES-1:0] data;
    logic [ETH_OUT_BYTES-1:0]   keep;
    logic                       last;
    logic                       err;
  } eth_word_t;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    DROP = 2'd1,
    TERM = 2'd2
  } pack_state_t;

endpackage

// File: rtl/eth_word_fifo.sv
// Synchronous word FIFO for packed output words.
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push       : write request; accepted when not full, or full with a pop
//   push_data  : word to write
//   pop        : read request; honoured when not empty
//   pop_data   : head entry, forced to zero while empty
//   full/empty : occupancy flags
module eth_word_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO is safe.
  assign push_ok = push && (!full || pop_ok);

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/eth_byte_packer.sv
// Packs an 8-bit receive byte stream into OUT_BYTES-wide words with a keep
// mask and hands them downstream through a word FIFO.
//   inData/inDataValid/inDataLast/inDataErr : byte stream, no backpressure
//   outData/outKeep/outValid/outLast/outErr : word stream, valid/ready
//   outReady : word is consumed on a cycle with outValid && outReady
//   overflow : one-cycle pulse (registered) when a word or the final byte
//              of a discarded frame is dropped for lack of FIFO space
// Handshake: outValid stays high and the word fields hold steady until the
// cycle in which outReady is sampled high; that cycle transfers the word.
module eth_byte_packer
  import eth_pkg::*;
#(
  parameter int OUT_BYTES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             inData,
  input  logic                   inDataValid,
  input  logic                   inDataLast,
  input  logic                   inDataErr,
  output logic [8*OUT_BYTES-1:0] outData,
  output logic [OUT_BYTES-1:0]   outKeep,
  output logic                   outValid,
  output logic                   outLast,
  output logic                   outErr,
  input  logic                   outReady,
  output logic                   overflow
);

  localparam int IDX_W = $clog2(OUT_BYTES);
  localparam int WW    = 8*OUT_BYTES + OUT_BYTES + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES-1);

  pack_state_t            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [8*OUT_BYTES-1:0] acc_q, acc_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;

  logic [8*OUT_BYTES-1:0] word_data;
  logic [OUT_BYTES-1:0]   word_keep;
  logic                   word_err;
  logic                   word_end;
  logic                   fifo_push;
  logic [WW-1:0]          push_word;
  logic [WW-1:0]          head_word;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic                   push_space;

  assign outValid = !fifo_empty;
  assign fifo_pop = outValid && outReady;
  assign {outData, outKeep, outLast, outErr} = head_word;
  assign overflow = overflow_q;
  // Mirrors the FIFO's own acceptance rule so the FSM knows whether a push lands.
  assign push_space = !fifo_full || fifo_pop;

  // Candidate word: accumulator with the current byte merged into lane idx.
  // Lanes above idx are zero because the accumulator is cleared on each push.
  always_comb begin
    word_data = acc_q;
    word_data[{idx_q, 3'b000} +: 8] = inData;
    for (int i = 0; i < OUT_BYTES; i++) begin
      word_keep[i] = (i <= int'(idx_q));
    end
    word_err = inDataLast && (frame_err_q || inDataErr);
    word_end = (idx_q == LAST_IDX) || inDataLast;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    frame_err_d = frame_err_q;
    overflow_d  = 1'b0;
    fifo_push   = 1'b0;
    push_word   = '0;
    case (state_q)
      PASS: begin
        if (inDataValid) begin
          if (word_end) begin
            fifo_push   = 1'b1;
            push_word   = {word_data, word_keep, inDataLast, word_err};
            idx_d       = '0;
            acc_d       = '0;
            frame_err_d = inDataLast ? 1'b0 : (frame_err_q || inDataErr);
            if (!push_space) begin
              // Frame is now truncated; the terminator carries the error.
              overflow_d  = 1'b1;
              frame_err_d = 1'b0;
              state_d     = inDataLast ? TERM : DROP;
            end
          end else begin
            acc_d       = word_data;
            idx_d       = idx_q + IDX_W'(1);
            frame_err_d = frame_err_q || inDataErr;
          end
        end
      end
      DROP: begin
        if (inDataValid && inDataLast) state_d = TERM;
      end
      TERM: begin
        fifo_push = 1'b1;
        push_word = {{(8*OUT_BYTES){1'b0}}, {OUT_BYTES{1'b0}}, 1'b1, 1'b1};
        if (push_space) state_d = PASS;
        // Any frame ending while we wait is lost entirely.
        if (inDataValid && inDataLast) overflow_d = 1'b1;
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PASS;
      idx_q       <= '0;
      acc_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  eth_word_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_eth_byte_packer.sv
module tb_eth_byte_packer;

  localparam int OB = 4;
  localparam int WW = 8*OB + OB + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    inData = '0;
  logic          inDataValid = 1'b0;
  logic          inDataLast = 1'b0;
  logic          inDataErr = 1'b0;
  logic [8*OB-1:0] outData;
  logic [OB-1:0] outKeep;
  logic          outValid;
  logic          outLast;
  logic          outErr;
  logic          outReady = 1'b1;
  logic          overflow;

  logic [WW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            ovf_cnt = 0;

  eth_byte_packer #(.OUT_BYTES(OB), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .inData      (inData),
    .inDataValid (inDataValid),
    .inDataLast  (inDataLast),
    .inDataErr   (inDataErr),
    .outData     (outData),
    .outKeep     (outKeep),
    .outValid    (outValid),
    .outLast     (outLast),
    .outErr      (outErr),
    .outReady    (outReady),
    .overflow    (overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%h keep=%h last=%b err=%b, required no word",
                 outData, outKeep, outLast, outErr);
      end else begin
        logic [WW-1:0] exp;
        exp = exp_q.pop_front();
        if ({outData, outKeep, outLast, outErr} !== exp) begin
          errors++;
          $display("FAIL word: got data=%h keep=%h last=%b err=%b, required data=%h keep=%h last=%b err=%b",
                   outData, outKeep, outLast, outErr,
                   exp[WW-1 -: 8*OB], exp[OB+1:2], exp[1], exp[0]);
        end
      end
    end
    if (!rst && overflow) ovf_cnt++;
  end

  function automatic logic [WW-1:0] mk(input logic [8*OB-1:0] d, input logic [OB-1:0] k,
                                       input logic l, input logic e);
    return {d, k, l, e};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic l, input logic e);
    @(posedge clk); #1;
    inData = b; inDataValid = 1'b1; inDataLast = l; inDataErr = e;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    inDataValid = 1'b0; inDataLast = 1'b0; inDataErr = 1'b0; inData = '0;
  endtask

  task automatic wait_drain(output bit ok);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    ok = (exp_q.size() == 0);
    repeat (4) @(negedge clk);  // let any stray extra word surface
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", outValid); end
    checks++; if (outLast !== 1'b0) begin errors++; $display("FAIL reset_last: got %b, required 0", outLast); end
    checks++; if (outErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", outErr); end
    checks++; if (outKeep !== '0) begin errors++; $display("FAIL reset_keep: got %h, required 0", outKeep); end
    checks++; if (outData !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", outData); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_full_frame();
    bit ok;
    exp_q.push_back(mk(32'h04030201, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h08070605, 4'hF, 1'b1, 1'b0));
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL latency_early: got outValid=%b, required 0", outValid); end
    send_byte(8'h05, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL latency_one: got outValid=%b, required 1", outValid); end
    send_byte(8'h06, 1'b0, 1'b0);
    send_byte(8'h07, 1'b0, 1'b0);
    send_byte(8'h08, 1'b1, 1'b0);
    idle();
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_frame_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_partial_word();
    bit ok;
    exp_q.push_back(mk(32'h14131211, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h00000015, 4'h1, 1'b1, 1'b0));
    for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i), (i == 4), 1'b0);
    idle();
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL partial_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_frame_err();
    bit ok;
    exp_q.push_back(mk(32'h24232221, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h00002625, 4'h3, 1'b1, 1'b1));
    for (int i = 0; i < 6; i++) send_byte(8'h21 + 8'(i), (i == 5), (i == 2));
    // next frame must not inherit the sticky error
    exp_q.push_back(mk(32'h00003231, 4'h3, 1'b1, 1'b0));
    send_byte(8'h31, 1'b0, 1'b0);
    send_byte(8'h32, 1'b1, 1'b0);
    idle();
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_overflow();
    bit ok;
    int ovf0;
    ovf0 = ovf_cnt;
    @(posedge clk); #1 outReady = 1'b0;
    for (int w = 0; w < 4; w++)
      exp_q.push_back(mk({8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}, 4'hF, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h0, 4'h0, 1'b1, 1'b1));
    for (int i = 1; i <= 24; i++) send_byte(8'(i), (i == 24), 1'b0);
    idle();
    repeat (4) @(negedge clk);
    checks++; if (ovf_cnt - ovf0 !== 1) begin errors++; $display("FAIL overflow_pulses: got %0d, required 1", ovf_cnt - ovf0); end
    checks++; if (outValid !== 1'b1 || outData !== 32'h04030201 || outKeep !== 4'hF) begin
      errors++; $display("FAIL hold_head: got valid=%b data=%h keep=%h, required 1 04030201 f", outValid, outData, outKeep);
    end
    @(posedge clk); #1 outReady = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL overflow_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    checks++; if (ovf_cnt - ovf0 !== 1) begin errors++; $display("FAIL overflow_after: got %0d, required 1", ovf_cnt - ovf0); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    idle();
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, required 0", outValid); end
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back(mk(32'hDDCCBBAA, 4'hF, 1'b1, 1'b0));
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    send_byte(8'hDD, 1'b1, 1'b0);
    idle();
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ovf0;
    logic [7:0] b;
    ovf0 = ovf_cnt;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(mk({24'h0, b}, 4'h1, 1'b1, 1'b0));
      send_byte(b, 1'b1, 1'b0);
      if (i >= 2) begin
        @(negedge clk);
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL b2b_stream: got outValid=%b, required 1", outValid); end
      end
    end
    idle();
    wait_drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    checks++; if (ovf_cnt != ovf0) begin errors++; $display("FAIL b2b_overflow: got %0d pulses, required 0", ovf_cnt - ovf0); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial_word();
    test_frame_err();
    test_overflow();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_byte_packer.md
Name: eth_byte_packer

Overview:
Packs the 8-bit byte stream from the RGMII/UDP receive path (data, valid, last, err) into OUT_BYTES-wide words with a byte-keep mask, ready for wider downstream parsing logic. Input has no backpressure, matching the PHY-side stream. Output is valid/ready, buffered by an internal word FIFO. FIFO overflow truncates the frame in a defined way, and per-frame error is carried to the frame's last word.

Parameters:
OUT_BYTES, 4, output word width in bytes (power of 2, 2..16)
FIFO_DEPTH, 4, output word FIFO depth in words (power of 2, >=2)

Ports:
clk  in  1  single clock for all logic
rst  in  1  asynchronous, active-high reset
inData  in  8  input byte
inDataValid  in  1  inData valid this cycle
inDataLast  in  1  qualifies the final byte of a frame (valid only with inDataValid)
inDataErr  in  1  byte carries an error (valid only with inDataValid)
outData  out  8*OUT_BYTES  packed word; first byte in bits [7:0]
outKeep  out  OUT_BYTES  byte-lane valid mask, contiguous from bit 0
outValid  out  1  word available
outLast  out  1  word is the last of its frame
outErr  out  1  frame had an error or was truncated (only on outLast word)
outReady  in  1  downstream accepts word when outValid&&outReady
overflow  out  1  one-cycle pulse when a word is dropped for lack of FIFO space

Behaviour:
- Reset: FIFO emptied, accumulator, lane index, err and drop flags cleared. outValid=0, outLast=0, outErr=0, outKeep=0, outData=0, overflow=0. Reset mid-frame discards the partial frame. Bytes after reset release are treated as the start of a new frame.
- Lane fill: each inDataValid byte is written to lane idx, then idx increments. Lane idx wraps to 0 after a word push.
- Word push: occurs on the cycle with inDataValid and either (idx==OUT_BYTES-1) or inDataLast. The pushed word is the accumulator plus the current byte, combined in the same cycle.
  - Keep = lanes 0..idx set; unused lanes are 0 in outData.
  - last = inDataLast.
  - err = inDataLast && (frameErr || inDataErr).
- Latency: final byte of a word presented at edge k with FIFO empty gives outValid=1 after edge k (1 cycle).
- frameErr: sticky, set by any inDataErr with valid. Cleared after the last word of the frame is pushed or terminated.
- FIFO: a push is accepted if not full, or if full with a simultaneous pop. Output is the head entry; it pops on outValid&&outReady. outData/outKeep/outLast/outErr hold while outValid&&!outReady.
- Overflow, state machine with three states:
  - PASS (normal): a push refused pulses overflow, then:
    - if the refused word had last=0, go to DROP;
    - if it had last=1, go to TERM.
  - DROP: discard bytes (no overflow pulse) until inDataLast, then go to TERM.
  - TERM: push one terminator word (keep=0, data=0, last=1, err=1) on the first cycle the FIFO accepts a push, then go to PASS.
    - Bytes arriving in TERM are discarded.
    - Each discarded frame's final byte in TERM pulses overflow.
- Simultaneous: a pop and a push in the same cycle never lose either.
- inDataLast/inDataErr without inDataValid are ignored.

Decomposition:
- Package eth_pkg: packed struct eth_word_t {data, keep, last, err} parameterised via OUT_BYTES localparam usage; enum pack_state_t {PASS, DROP, TERM}.
- Sub-module eth_word_fifo: synchronous FIFO of eth_word_t, DEPTH parameter, full/empty, same-cycle push-when-full-with-pop support.

Test Plan:
1. 8-byte frame 01..08, outReady=1 -> words 0x04030201 keep 0xF last0, then 0x08070605 keep 0xF last1 err0; first outValid 1 cycle after byte 04.
2. 5-byte frame 11..15 -> 0x14131211 keep 0xF, then 0x00000015 keep 0x1 last1.
3. 6-byte frame with inDataErr on byte 3 -> word0 err0, word1 keep 0x3 last1 err1; next clean frame has err0.
4. outReady=0, FIFO_DEPTH=4, 24-byte frame -> 4 words buffered, overflow pulses once at 5th word. Then raise outReady -> 4 data words followed by terminator keep0 last1 err1, no further words.
5. rst pulsed after 2 bytes of a frame, then frame AA BB CC DD -> single word 0xDDCCBBAA keep 0xF last1; no residue of earlier bytes.
6. Back-to-back 1-byte frames every cycle with outReady=1 -> one word per cycle, keep 0x1 last1, no overflow.
